// File: rtl/ic74194.sv
// 4-bit bidirectional universal shift register: hold, shift right, shift left,
// parallel load, with an asynchronous active-low clear.

module ic74194_cell (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       from_lo,
    input  logic       from_hi,
    input  logic       par,
    output logic       q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (mode)
                2'b00:   q <= q;
                2'b01:   q <= from_lo;
                2'b10:   q <= from_hi;
                default: q <= par;
            endcase
        end
    end

endmodule

module ic74194 (
    input  logic pin_11,
    input  logic pin_1,
    input  logic pin_9,
    input  logic pin_10,
    input  logic pin_2,
    input  logic pin_7,
    input  logic pin_3,
    input  logic pin_4,
    input  logic pin_5,
    input  logic pin_6,
    output logic pin_15,
    output logic pin_14,
    output logic pin_13,
    output logic pin_12
);

    localparam int NUM_BITS = 4;

    logic [1:0]          mode;
    logic [NUM_BITS-1:0] q;
    logic [NUM_BITS-1:0] par;
    logic [NUM_BITS-1:0] lo;
    logic [NUM_BITS-1:0] hi;

    assign mode = {pin_10, pin_9};
    assign par  = {pin_6, pin_5, pin_4, pin_3};

    // Shift right moves data toward QD, so each bit takes its lower neighbour;
    // the vacated ends take the serial inputs, nothing wraps.
    assign lo = {q[NUM_BITS-2:0], pin_2};
    assign hi = {pin_7, q[NUM_BITS-1:1]};

    for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
        ic74194_cell u_cell (
            .clk     (pin_11),
            .rst_n   (pin_1),
            .mode    (mode),
            .from_lo (lo[i]),
            .from_hi (hi[i]),
            .par     (par[i]),
            .q       (q[i])
        );
    end

    assign pin_15 = q[0];
    assign pin_14 = q[1];
    assign pin_13 = q[2];
    assign pin_12 = q[3];

endmodule

// File: tb/tb_ic74194.sv
// Directed bench for ic74194: clear, load/hold, both shift directions,
// direction reversal and clear across a load edge.

module tb_ic74194;

    logic       clk;
    logic       clr;
    logic [1:0] s;
    logic       sr;
    logic       sl;
    logic [3:0] d;
    logic       qa, qb, qc, qd;
    logic [3:0] q;

    int passed = 0;
    int total  = 0;

    ic74194 dut (
        .pin_11 (clk),
        .pin_1  (clr),
        .pin_9  (s[0]),
        .pin_10 (s[1]),
        .pin_2  (sr),
        .pin_7  (sl),
        .pin_3  (d[0]),
        .pin_4  (d[1]),
        .pin_5  (d[2]),
        .pin_6  (d[3]),
        .pin_15 (qa),
        .pin_14 (qb),
        .pin_13 (qc),
        .pin_12 (qd)
    );

    assign q = {qd, qc, qb, qa};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp);
        total++;
        assert (q === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, q, exp);
    endtask

    // Drive inputs at the falling edge, clock once, sample 1 after the rise.
    task automatic step(input logic [1:0] mode, input logic sr_v, input logic sl_v,
                        input logic [3:0] d_v);
        @(negedge clk);
        s  = mode;
        sr = sr_v;
        sl = sl_v;
        d  = d_v;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        #2 clr = 1'b0;
        #1 clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0;
        s   = 2'b00;
        sr  = 1'b0;
        sl  = 1'b0;
        d   = 4'b0000;
        #12;
        check("reset_state", 4'b0000);
        step(2'b11, 1'b1, 1'b1, 4'b1111);
        check("clear_held_edges", 4'b0000);
        @(negedge clk);
        clr = 1'b1;

        // Clear between edges from 1111, then held low with load pending
        step(2'b11, 1'b0, 1'b0, 4'b1111);
        check("preset_1111", 4'b1111);
        @(negedge clk);
        #2 clr = 1'b0;
        #1 check("clear_async", 4'b0000);
        s = 2'b11;
        d = 4'b1010;
        @(posedge clk);
        #1 check("clear_hold_edge1", 4'b0000);
        @(posedge clk);
        #1 check("clear_hold_edge2", 4'b0000);
        @(negedge clk);
        clr = 1'b1;

        // Load then hold with data and serial inputs toggling
        step(2'b11, 1'b0, 1'b0, 4'b1001);
        check("load_1001", 4'b1001);
        step(2'b00, 1'b1, 1'b1, 4'b0110);
        check("hold_1", 4'b1001);
        step(2'b00, 1'b0, 1'b1, 4'b1111);
        check("hold_2", 4'b1001);
        step(2'b00, 1'b1, 1'b0, 4'b0000);
        check("hold_3", 4'b1001);

        // Shift right, pin_7 and parallel data toggling
        pulse_clear();
        check("clear_before_sr", 4'b0000);
        step(2'b01, 1'b1, 1'b1, 4'b1111);
        check("sr_1", 4'b0001);
        step(2'b01, 1'b0, 1'b0, 4'b0000);
        check("sr_2", 4'b0010);
        step(2'b01, 1'b1, 1'b1, 4'b1010);
        check("sr_3", 4'b0101);
        step(2'b01, 1'b1, 1'b0, 4'b0101);
        check("sr_4", 4'b1011);

        // Shift left, pin_2 toggling
        pulse_clear();
        check("clear_before_sl", 4'b0000);
        step(2'b10, 1'b1, 1'b1, 4'b1111);
        check("sl_1", 4'b1000);
        step(2'b10, 1'b0, 1'b1, 4'b0000);
        check("sl_2", 4'b1100);
        step(2'b10, 1'b1, 1'b0, 4'b1111);
        check("sl_3", 4'b0110);
        step(2'b10, 1'b0, 1'b1, 4'b0000);
        check("sl_4", 4'b1011);

        // Direction reversal
        step(2'b11, 1'b1, 1'b1, 4'b0110);
        check("rev_load", 4'b0110);
        step(2'b01, 1'b0, 1'b0, 4'b1111);
        check("rev_sr", 4'b1100);
        step(2'b10, 1'b0, 1'b1, 4'b0000);
        check("rev_sl", 4'b1110);

        // Clear held low across a load edge, then load on release
        @(negedge clk);
        s   = 2'b11;
        d   = 4'b1111;
        clr = 1'b0;
        @(posedge clk);
        #1 check("clr_across_load", 4'b0000);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1 check("load_after_release", 4'b1111);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
